fixed_point_multiplication: RTL and testbench

- Registered signed fixed-point multiplier for the digital-filter datapath.
- Operates on N-bit words with N/2 fractional bits (Q8.8 at N=16).
- Uses the datapath's "inverted-integer" signed encoding and saturates on overflow.
- Feeds the filter's accumulate stage.

---
 rtl/fixed_point_multiplication.sv | 88 ++++++++
 tb/tb_fixed_point_multiplication.sv | 133 +++++++++++++
 2 files changed

// File: rtl/fixed_point_multiplication.sv
// Registered signed fixed-point multiplier (QN/2.N/2) using the inverted-integer sign encoding, saturating.
// Optional: define MULT_OVERFLOW_FLAG_EN to add the registered saturation flag output ovf.
module fixed_point_multiplication #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
`ifdef MULT_OVERFLOW_FLAG_EN
  output logic         ovf,
`endif
  output logic [N-1:0] Result
);

  localparam int F  = N / 2;
  localparam int PW = 2 * N - 2;
  localparam int QW = PW - F;
  localparam logic [QW-1:0] QMAX = QW'({(N-1){1'b1}});

  // Negative words carry an inverted integer field; the magnitude MSB is always 0, so it is dropped.
  function automatic logic [N-2:0] decode(input logic [N-1:0] w);
    return w[N-1] ? {~w[N-2:F], w[F-1:0]} : w[N-2:0];
  endfunction

  function automatic logic [N-1:0] encode(input logic s, input logic [N-2:0] m);
    return (s && (m != '0)) ? {1'b1, ~m[N-2:F], m[F-1:0]} : {1'b0, m};
  endfunction

  logic [N-2:0] mag_a, mag_b, q_sat;
  logic [PW-1:0] prod;
  logic [QW-1:0] q_full;
  logic          sat;

  assign mag_a  = decode(A);
  assign mag_b  = decode(B);
  assign prod   = PW'(mag_a) * PW'(mag_b);
  assign q_full = QW'(prod >> F);
  assign sat    = q_full > QMAX;
  assign q_sat  = sat ? '1 : q_full[N-2:0];

  logic [N-1:0] result_d, result_q;
  logic         valid_d, valid_q;
`ifdef MULT_OVERFLOW_FLAG_EN
  logic         ovf_d, ovf_q;
`endif

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    result_d = result_q;
    valid_d  = in_valid;
`ifdef MULT_OVERFLOW_FLAG_EN
    ovf_d    = ovf_q;
`endif
    if (in_valid) begin
      result_d = encode(A[N-1] ^ B[N-1], q_sat);
`ifdef MULT_OVERFLOW_FLAG_EN
      ovf_d    = sat;
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      valid_q  <= 1'b0;
`ifdef MULT_OVERFLOW_FLAG_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
`ifdef MULT_OVERFLOW_FLAG_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign Result    = result_q;
  assign out_valid = valid_q;
`ifdef MULT_OVERFLOW_FLAG_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_fixed_point_multiplication.sv
// Scoreboard bench for fixed_point_multiplication: directed vectors, one expectation per clock edge.
// Optional MULT_OVERFLOW_FLAG_EN also checks the ovf output.
module tb_fixed_point_multiplication;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [N-1:0] A, B;
  logic         out_valid;
  logic [N-1:0] Result;
`ifdef MULT_OVERFLOW_FLAG_EN
  logic         ovf;
`endif

  fixed_point_multiplication #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
`ifdef MULT_OVERFLOW_FLAG_EN
    .ovf      (ovf),
`endif
    .Result   (Result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         vld;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         exp_valid;
    logic [N-1:0] exp_result;
    logic         exp_ovf;
    string        name;
  } vec_t;

  typedef struct {
    logic         valid;
    logic [N-1:0] result;
    logic         ovf;
    string        name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                     input logic ev, input logic [N-1:0] er, input logic eo, input string name);
    vec_t t;
    t = '{rst: r, vld: v, a: a, b: b, exp_valid: ev, exp_result: er, exp_ovf: eo, name: name};
    vecs.push_back(t);
  endtask

  // Monitor: one expectation per edge, sampled 1 time unit after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".out_valid"}, 32'(out_valid), 32'(e.valid));
        check({e.name, ".Result"}, 32'(Result), 32'(e.result));
`ifdef MULT_OVERFLOW_FLAG_EN
        check({e.name, ".ovf"}, 32'(ovf), 32'(e.ovf));
`endif
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0;

    //   rst   vld   A         B          valid Result    ovf
    add(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, "reset");
    add(1'b0, 1'b1, 16'h0180, 16'h0340, 1'b1, 16'h04E0, 1'b0, "pos_x_pos");
    add(1'b0, 1'b1, 16'hFE80, 16'h0340, 1'b1, 16'hFBE0, 1'b0, "neg_x_pos");
    add(1'b0, 1'b1, 16'h0340, 16'hFE80, 1'b1, 16'hFBE0, 1'b0, "swapped");
    add(1'b0, 1'b1, 16'h7F80, 16'h0540, 1'b1, 16'h7FFF, 1'b1, "pos_sat");
    add(1'b0, 1'b1, 16'h8080, 16'h0540, 1'b1, 16'h80FF, 1'b1, "neg_sat");
    add(1'b0, 1'b1, 16'hFF00, 16'h0340, 1'b1, 16'h0000, 1'b0, "neg_zero_in");
    add(1'b0, 1'b1, 16'h0180, 16'h0340, 1'b1, 16'h04E0, 1'b0, "stream");
    add(1'b0, 1'b0, 16'h7F80, 16'h0540, 1'b0, 16'h04E0, 1'b0, "hold1");
    add(1'b0, 1'b0, 16'h0180, 16'hFE80, 1'b0, 16'h04E0, 1'b0, "hold2");
    add(1'b0, 1'b1, 16'h0100, 16'h8100, 1'b1, 16'h8100, 1'b0, "one_x_neg126");
    add(1'b0, 1'b1, 16'hFF80, 16'h0001, 1'b1, 16'h0000, 1'b0, "trunc_no_negzero");
    add(1'b0, 1'b1, 16'hFE80, 16'hFE80, 1'b1, 16'h0240, 1'b0, "neg_x_neg");
    add(1'b0, 1'b1, 16'h7FFF, 16'h0100, 1'b1, 16'h7FFF, 1'b0, "pos_max_exact");
    add(1'b0, 1'b1, 16'h80FF, 16'h0100, 1'b1, 16'h80FF, 1'b0, "neg_max_exact");
    add(1'b0, 1'b1, 16'h7F80, 16'h0540, 1'b1, 16'h7FFF, 1'b1, "sat_again");
    add(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h7FFF, 1'b1, "ovf_hold");
    add(1'b1, 1'b1, 16'h0180, 16'h0340, 1'b0, 16'h0000, 1'b0, "rst_over_valid");
    add(1'b0, 1'b0, 16'h0180, 16'h0340, 1'b0, 16'h0000, 1'b0, "post_reset_idle");

    foreach (vecs[i]) begin
      exp_t e;
      @(negedge clk);
      rst      = vecs[i].rst;
      in_valid = vecs[i].vld;
      A        = vecs[i].a;
      B        = vecs[i].b;
      e = '{valid: vecs[i].exp_valid, result: vecs[i].exp_result, ovf: vecs[i].exp_ovf, name: vecs[i].name};
      sb.push_back(e);
    end

    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 10 && sb.size() > 0; c++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
